acc_cmd_endpoint: RTL and testbench
===================================

// Module: acc_cmd_endpoint
// PURPOSE
// - Accelerator-side end of the manager command protocol.
// - Receives execute-task packets on the cmdin stream and stores the task/parent IDs and arguments.
// - Starts the accelerator core, then returns a finish packet on the cmdout stream when the core signals done.
// - One instance per accelerator, between the manager's cmdin/cmdout streams and the HLS/RTL core.
// PARAMETERS
// - ACC_BITS  4   width of the accelerator ID / cmdout tid
// - ACC_ID    0   this accelerator's ID; sent in the finish header and tid
// - MAX_ARGS  15  argument slots held (1..255)
// - ARG_BITS  $clog2(MAX_ARGS)  argument read-address width (minimum 1)
// PORTS
// - clk               in   1         single clock
// - rst               in   1         asynchronous, active-high reset
// - cmdin_in_tvalid   in   1         command stream from manager
// - cmdin_in_tready   out  1
// - cmdin_in_tdata    in   64
// - cmdin_in_tlast    in   1
// - cmdout_out_tvalid out  1         finish stream to manager
// - cmdout_out_tready in   1
// - cmdout_out_tid    out  ACC_BITS  constant ACC_ID
// - cmdout_out_tdata  out  64
// - cmdout_out_tlast  out  1
// - core_start        out  1         1-cycle start pulse
// - core_busy         out  1         high from start until the finish packet is fully sent
// - core_task_id      out  64        task ID of the current task
// - core_nargs        out  8         argument count of the current task
// - core_arg_addr     in   ARG_BITS  argument read address
// - core_arg_data     out  64        registered read data, 1-cycle latency
// - core_done         in   1         completion pulse; sampled only in RUN
// PROTOCOL / BEHAVIOUR
// - Execute packet, in order:
//   - W0 header: [7:0]=CMD_EXEC_TASK (8'h01), [15:8]=nargs, rest reserved
//   - W1 task_id
//   - W2 parent_id
//   - W3.. args, with tlast on the last word
// - Finish packet, 3 words:
//   - W0 header: [7:0]=CMD_FINISH_TASK (8'h03), [15:8]=ACC_ID, rest 0
//   - W1 task_id
//   - W2 parent_id, with tlast
// - States: HDR, TID, PTID, ARGS, START, RUN, FHDR, FTID, FPTID, DRAIN.
// - cmdin_in_tready is 1 only in HDR/TID/PTID/ARGS/DRAIN. A word is accepted on tvalid&tready.
// - HDR transitions:
//   - Valid code and nargs<=MAX_ARGS -> TID.
//   - Any other header -> DRAIN; with tlast on the header -> HDR directly.
// - TID -> PTID. PTID -> ARGS if nargs>0, else START.
// - ARGS: word k is written to slot k. After nargs words -> START.
// - Early tlast (in TID/PTID, or ARGS before nargs words) aborts: -> HDR, no start.
// - Extra words after the nargs-th arg without tlast -> DRAIN; no start for that packet.
// - DRAIN: discard words until tlast -> HDR.
// - START: core_start=1 for exactly one cycle, then RUN. Latency is one cycle after the last accepted word.
// - RUN: core_done -> FHDR. cmdout_out_tvalid rises the cycle after done is sampled.
// - FHDR/FTID/FPTID: tvalid held; tdata stable until tready. Advance on tready; FPTID -> HDR.
// - No new command is accepted until the finish packet completes. Back-pressure is held on cmdin.
// - core_done outside RUN is ignored. core_done in the START cycle is ignored.
// - core_arg_addr >= nargs returns stale slot contents; this is undefined data but never an error.
// - Reset values:
//   - State HDR.
//   - tready, tvalid, tlast, core_start, core_busy = 0.
//   - tdata, core_task_id, core_nargs, core_arg_data = 0.
//   - The arg store is not reset.
// - Reset mid-packet or mid-RUN abandons the task silently; no finish packet is sent.
// CONFIGURATION
// - Macro ACC_CMD_ENDPOINT_ERRCNT_EN.
// - Defined: adds output err_count[15:0], reset 0.
//   - Increments once per discarded/aborted packet: bad code, nargs>MAX_ARGS, early tlast, extra words.
//   - Saturates at 16'hFFFF.
// - Undefined: port and counter are absent. Protocol behaviour is identical either way.
// STRUCTURE
// - Package OmpSsManager holds CMD_EXEC_TASK, CMD_FINISH_TASK, the header field offsets, and the state enum typedef.
// - One sub-module, acc_arg_regfile:
//   - MAX_ARGS x 64.
//   - 1 write port (FSM) and 1 registered read port (core).
//   - Inferred distributed RAM.
// TESTING
// - Execute packet: hdr 0x0000_0201, tid 0xAA, ptid 0xBB, args 0x11, 0x22(tlast).
//   -> core_start pulse 1 cycle after 0x22 accepted; nargs=2; arg reads 0x11/0x22; task_id=0xAA.
// - core_done after 10 cycles with cmdout_out_tready=0 for 5 cycles.
//   -> finish words 0x0000_0003|(ACC_ID<<8), 0xAA, 0xBB(tlast) held stable; cmdin_in_tready=0 throughout.
// - nargs=0 packet: hdr 0x01, tid 0x5, ptid 0x6(tlast) -> start 1 cycle after ptid; finish carries 0x5/0x6.
// - Bad header 0x0000_0007 followed by 3 words (last tlast) -> all consumed, no start; err_count=1 with the macro.
// - Early tlast on the arg-1 word of a nargs=3 packet -> HDR, no start; the next valid packet runs normally.
// - Reset asserted during RUN -> all outputs at reset values next cycle, no finish sent; a new packet is accepted after release.

Source files
------------

// File: rtl/acc_cmd_endpoint_pkg.sv
// Shared definitions for the accelerator command endpoint: command codes,
// header field positions and the endpoint state encoding.
package OmpSsManager;

    localparam logic [7:0] CMD_EXEC_TASK   = 8'h01;
    localparam logic [7:0] CMD_FINISH_TASK = 8'h03;

    localparam int HDR_CODE_LSB  = 0;
    localparam int HDR_CODE_MSB  = 7;
    localparam int HDR_NARGS_LSB = 8;
    localparam int HDR_NARGS_MSB = 15;
    localparam int HDR_ACC_LSB   = 8;
    localparam int HDR_ACC_MSB   = 15;

    typedef enum logic [3:0] {
        ST_HDR,
        ST_TID,
        ST_PTID,
        ST_ARGS,
        ST_START,
        ST_RUN,
        ST_FHDR,
        ST_FTID,
        ST_FPTID,
        ST_DRAIN
    } cmd_state_t;

endpackage

// File: rtl/acc_arg_regfile.sv
// Argument store: one write port from the command FSM, one registered read
// port for the core. The array itself has no reset so it maps to LUT RAM.
module acc_arg_regfile
    import OmpSsManager::*;
#(
    parameter int DEPTH  = 15,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Addresses past the last slot keep the previous read value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (int'(rd_addr) < DEPTH) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/acc_cmd_endpoint.sv
// Accelerator-side command endpoint: parses execute-task packets, starts the
// core and returns a finish packet. Optional error counter: ACC_CMD_ENDPOINT_ERRCNT_EN.
module acc_cmd_endpoint
    import OmpSsManager::*;
#(
    parameter int ACC_BITS = 4,
    parameter int ACC_ID   = 0,
    parameter int MAX_ARGS = 15,
    parameter int ARG_BITS = (MAX_ARGS > 1) ? $clog2(MAX_ARGS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmdin_in_tvalid,
    output logic                cmdin_in_tready,
    input  logic [63:0]         cmdin_in_tdata,
    input  logic                cmdin_in_tlast,
    output logic                cmdout_out_tvalid,
    input  logic                cmdout_out_tready,
    output logic [ACC_BITS-1:0] cmdout_out_tid,
    output logic [63:0]         cmdout_out_tdata,
    output logic                cmdout_out_tlast,
    output logic                core_start,
    output logic                core_busy,
    output logic [63:0]         core_task_id,
    output logic [7:0]          core_nargs,
    input  logic [ARG_BITS-1:0] core_arg_addr,
    output logic [63:0]         core_arg_data,
    input  logic                core_done
`ifdef ACC_CMD_ENDPOINT_ERRCNT_EN
    ,
    output logic [15:0]         err_count
`endif
);

    localparam logic [7:0] MAX_ARGS_B = 8'(MAX_ARGS);
    localparam logic [7:0] ACC_ID_B   = 8'(ACC_ID);

    cmd_state_t  state;
    cmd_state_t  state_nxt;
    logic [7:0]  arg_cnt;
    logic [63:0] ptid_q;
    logic [63:0] fin_hdr;
    logic        acc;
    logic        hdr_ok;
    logic        last_arg;

    assign acc      = cmdin_in_tvalid && cmdin_in_tready;
    assign hdr_ok   = (cmdin_in_tdata[HDR_CODE_MSB:HDR_CODE_LSB] == CMD_EXEC_TASK) &&
                      (cmdin_in_tdata[HDR_NARGS_MSB:HDR_NARGS_LSB] <= MAX_ARGS_B);
    assign last_arg = (arg_cnt == core_nargs - 8'd1);
    assign cmdout_out_tid = ACC_BITS'(ACC_ID);

    always_comb begin
        fin_hdr = '0;
        fin_hdr[HDR_CODE_MSB:HDR_CODE_LSB] = CMD_FINISH_TASK;
        fin_hdr[HDR_ACC_MSB:HDR_ACC_LSB]   = ACC_ID_B;
    end

    // A tlast that arrives early returns straight to HDR; surplus words go through DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HDR: if (acc) begin
                if (cmdin_in_tlast)  state_nxt = ST_HDR;
                else if (hdr_ok)     state_nxt = ST_TID;
                else                 state_nxt = ST_DRAIN;
            end
            ST_TID:   if (acc) state_nxt = cmdin_in_tlast ? ST_HDR : ST_PTID;
            ST_PTID: if (acc) begin
                if (core_nargs == 8'd0) state_nxt = cmdin_in_tlast ? ST_START : ST_DRAIN;
                else                    state_nxt = cmdin_in_tlast ? ST_HDR : ST_ARGS;
            end
            ST_ARGS: if (acc) begin
                if (last_arg)            state_nxt = cmdin_in_tlast ? ST_START : ST_DRAIN;
                else if (cmdin_in_tlast) state_nxt = ST_HDR;
            end
            ST_START: state_nxt = ST_RUN;
            ST_RUN:   if (core_done) state_nxt = ST_FHDR;
            ST_FHDR:  if (cmdout_out_tready) state_nxt = ST_FTID;
            ST_FTID:  if (cmdout_out_tready) state_nxt = ST_FPTID;
            ST_FPTID: if (cmdout_out_tready) state_nxt = ST_HDR;
            ST_DRAIN: if (acc && cmdin_in_tlast) state_nxt = ST_HDR;
            default:  state_nxt = ST_HDR;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_HDR;
            cmdin_in_tready   <= 1'b0;
            cmdout_out_tvalid <= 1'b0;
            cmdout_out_tlast  <= 1'b0;
            cmdout_out_tdata  <= '0;
            core_start        <= 1'b0;
            core_busy         <= 1'b0;
            core_task_id      <= '0;
            core_nargs        <= '0;
            arg_cnt           <= '0;
        end else begin
            state             <= state_nxt;
            cmdin_in_tready   <= state_nxt inside {ST_HDR, ST_TID, ST_PTID, ST_ARGS, ST_DRAIN};
            core_start        <= (state_nxt == ST_START);
            core_busy         <= state_nxt inside {ST_START, ST_RUN, ST_FHDR, ST_FTID, ST_FPTID};
            cmdout_out_tvalid <= state_nxt inside {ST_FHDR, ST_FTID, ST_FPTID};
            cmdout_out_tlast  <= (state_nxt == ST_FPTID);
            case (state_nxt)
                ST_FHDR:  cmdout_out_tdata <= fin_hdr;
                ST_FTID:  cmdout_out_tdata <= core_task_id;
                ST_FPTID: cmdout_out_tdata <= ptid_q;
                default:  ;
            endcase
            if (acc) begin
                case (state)
                    ST_HDR: if (hdr_ok) begin
                        core_nargs <= cmdin_in_tdata[HDR_NARGS_MSB:HDR_NARGS_LSB];
                        arg_cnt    <= '0;
                    end
                    ST_TID:  core_task_id <= cmdin_in_tdata;
                    ST_ARGS: arg_cnt <= arg_cnt + 8'd1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc && state == ST_PTID) begin
            ptid_q <= cmdin_in_tdata;
        end
    end

    acc_arg_regfile #(
        .DEPTH  (MAX_ARGS),
        .ADDR_W (ARG_BITS),
        .DATA_W (64)
    ) u_args (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (acc && state == ST_ARGS),
        .wr_addr (arg_cnt[ARG_BITS-1:0]),
        .wr_data (cmdin_in_tdata),
        .rd_addr (core_arg_addr),
        .rd_data (core_arg_data)
    );

`ifdef ACC_CMD_ENDPOINT_ERRCNT_EN
    logic err_inc;

    // Any accepted word that ends a packet without reaching START is an error.
    assign err_inc = acc && (state != ST_DRAIN) &&
                     (state_nxt == ST_HDR || state_nxt == ST_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_inc && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_acc_cmd_endpoint.sv
// Scoreboard bench for acc_cmd_endpoint: random packets against a packet-level model.
module tb_acc_cmd_endpoint;

    localparam int ACC_BITS = 4;
    localparam int ACC_ID   = 5;
    localparam int MAX_ARGS = 15;
    localparam int ARG_BITS = 4;

    logic                clk;
    logic                rst;
    logic                cmdin_in_tvalid;
    logic                cmdin_in_tready;
    logic [63:0]         cmdin_in_tdata;
    logic                cmdin_in_tlast;
    logic                cmdout_out_tvalid;
    logic                cmdout_out_tready;
    logic [ACC_BITS-1:0] cmdout_out_tid;
    logic [63:0]         cmdout_out_tdata;
    logic                cmdout_out_tlast;
    logic                core_start;
    logic                core_busy;
    logic [63:0]         core_task_id;
    logic [7:0]          core_nargs;
    logic [ARG_BITS-1:0] core_arg_addr;
    logic [63:0]         core_arg_data;
    logic                core_done;
`ifdef ACC_CMD_ENDPOINT_ERRCNT_EN
    logic [15:0]         err_count;
`endif

    acc_cmd_endpoint #(
        .ACC_BITS (ACC_BITS),
        .ACC_ID   (ACC_ID),
        .MAX_ARGS (MAX_ARGS),
        .ARG_BITS (ARG_BITS)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmdin_in_tvalid   (cmdin_in_tvalid),
        .cmdin_in_tready   (cmdin_in_tready),
        .cmdin_in_tdata    (cmdin_in_tdata),
        .cmdin_in_tlast    (cmdin_in_tlast),
        .cmdout_out_tvalid (cmdout_out_tvalid),
        .cmdout_out_tready (cmdout_out_tready),
        .cmdout_out_tid    (cmdout_out_tid),
        .cmdout_out_tdata  (cmdout_out_tdata),
        .cmdout_out_tlast  (cmdout_out_tlast),
        .core_start        (core_start),
        .core_busy         (core_busy),
        .core_task_id      (core_task_id),
        .core_nargs        (core_nargs),
        .core_arg_addr     (core_arg_addr),
        .core_arg_data     (core_arg_data),
        .core_done         (core_done)
`ifdef ACC_CMD_ENDPOINT_ERRCNT_EN
        ,
        .err_count         (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  nargs;
        logic [63:0] tid;
        logic [63:0] ptid;
        logic [63:0] args [16];
    } task_t;

    int          checks   = 0;
    int          failures = 0;
    int          err_exp  = 0;
    bit          hold_done = 1'b0;
    bit          abandon   = 1'b0;
    task_t       start_q [$];
    logic [64:0] fin_q [$];
    logic [63:0] pkt [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_now(input string name, input int waited);
        checks++;
        failures++;
        $display("FAIL %s waited=%0d cycles, required completion within limit", name, waited);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmdin_tready"}, 64'(cmdin_in_tready), 64'd0);
        chk({tag, "_cmdout_tvalid"}, 64'(cmdout_out_tvalid), 64'd0);
        chk({tag, "_cmdout_tlast"}, 64'(cmdout_out_tlast), 64'd0);
        chk({tag, "_cmdout_tdata"}, cmdout_out_tdata, 64'd0);
        chk({tag, "_core_start"}, 64'(core_start), 64'd0);
        chk({tag, "_core_busy"}, 64'(core_busy), 64'd0);
        chk({tag, "_core_task_id"}, core_task_id, 64'd0);
        chk({tag, "_core_nargs"}, 64'(core_nargs), 64'd0);
        chk({tag, "_core_arg_data"}, core_arg_data, 64'd0);
`ifdef ACC_CMD_ENDPOINT_ERRCNT_EN
        chk({tag, "_err_count"}, 64'(err_count), 64'd0);
`endif
    endtask

    // Packet-level model: a packet starts the core only if its code is EXEC,
    // its nargs fits, and its length is exactly 3 + nargs words.
    task automatic send_pkt();
        task_t t;
        int    n;
        int    len;
        int    waited;
        bit    good;
        len  = pkt.size();
        n    = int'(pkt[0][15:8]);
        good = (pkt[0][7:0] == 8'h01) && (n <= MAX_ARGS) && (len == 3 + n);
        if (good) begin
            t.nargs = pkt[0][15:8];
            t.tid   = pkt[1];
            t.ptid  = pkt[2];
            for (int k = 0; k < 16; k++) begin
                t.args[k] = '0;
                if (k < n) t.args[k] = pkt[3 + k];
            end
            start_q.push_back(t);
        end else begin
            err_exp++;
        end
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                cmdin_in_tvalid = 1'b0;
            end
            @(negedge clk);
            cmdin_in_tvalid = 1'b1;
            cmdin_in_tdata  = pkt[i];
            cmdin_in_tlast  = (i == len - 1);
            waited = 0;
            while (!cmdin_in_tready) begin
                @(negedge clk);
                waited++;
                if (waited > 3000) finish_now("cmdin_accept_timeout", waited);
            end
            @(posedge clk);
        end
        @(negedge clk);
        cmdin_in_tvalid = 1'b0;
        cmdin_in_tlast  = 1'b0;
`ifdef ACC_CMD_ENDPOINT_ERRCNT_EN
        chk("err_count", 64'(err_count), 64'(err_exp));
`endif
    endtask

    task automatic gen_random_pkt();
        int          kind;
        int          n;
        int          len;
        logic [63:0] hdr;
        kind = $urandom_range(0, 5);
        n    = ($urandom_range(0, 9) == 0) ? MAX_ARGS : $urandom_range(0, 5);
        hdr  = {$urandom, $urandom};
        hdr[7:0]  = 8'h01;
        hdr[15:8] = 8'(n);
        len  = 3 + n;
        case (kind)
            3: begin
                if ($urandom_range(0, 1) == 1) begin
                    hdr[7:0] = 8'($urandom_range(2, 255));
                end else begin
                    hdr[15:8] = 8'($urandom_range(MAX_ARGS + 1, 255));
                end
                len = $urandom_range(1, 6);
            end
            4: len = $urandom_range(1, 2 + n);
            5: len = 3 + n + $urandom_range(1, 3);
            default: ;
        endcase
        pkt.delete();
        pkt.push_back(hdr);
        for (int i = 1; i < len; i++) pkt.push_back({$urandom, $urandom});
    endtask

    // Core model: checks the start view and argument reads, then raises done.
    initial begin
        task_t t;
        core_done     = 1'b0;
        core_arg_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst && core_start) begin
                if (start_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start actual=1 required=0");
                end else begin
                    t = start_q.pop_front();
                    chk("start_nargs", 64'(core_nargs), 64'(t.nargs));
                    chk("start_task_id", core_task_id, t.tid);
                    chk("busy_at_start", 64'(core_busy), 64'd1);
                    if ($urandom_range(0, 1) == 1) core_done = 1'b1;
                    @(negedge clk);
                    core_done = 1'b0;
                    chk("start_one_cycle", 64'(core_start), 64'd0);
                    for (int k = 0; k < int'(t.nargs); k++) begin
                        core_arg_addr = ARG_BITS'(k);
                        @(negedge clk);
                        chk("arg_data", core_arg_data, t.args[k]);
                    end
                    repeat ($urandom_range(1, 12)) @(negedge clk);
                    while (hold_done) @(negedge clk);
                    if (abandon) begin
                        abandon = 1'b0;
                    end else begin
                        chk("no_finish_before_done", 64'(cmdout_out_tvalid), 64'd0);
                        fin_q.push_back({1'b0, 48'h0, 8'(ACC_ID), 8'h03});
                        fin_q.push_back({1'b0, t.tid});
                        fin_q.push_back({1'b1, t.ptid});
                        core_done = 1'b1;
                        @(negedge clk);
                        core_done = 1'b0;
                        chk("finish_valid_after_done", 64'(cmdout_out_tvalid), 64'd1);
                    end
                end
            end
        end
    end

    // Finish-stream monitor with random back-pressure; first finish stalls 5 cycles.
    initial begin
        logic [63:0] held_d;
        logic [64:0] e;
        bit          held;
        int          stall_left;
        held       = 1'b0;
        held_d     = '0;
        stall_left = 5;
        cmdout_out_tready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (core_busy) chk("cmdin_tready_low_while_busy", 64'(cmdin_in_tready), 64'd0);
            if (cmdout_out_tvalid && stall_left > 0) begin
                cmdout_out_tready = 1'b0;
                stall_left--;
            end else begin
                cmdout_out_tready = ($urandom_range(0, 2) != 0);
            end
            if (cmdout_out_tvalid) begin
                if (held) chk("finish_data_stable", cmdout_out_tdata, held_d);
                if (cmdout_out_tready) begin
                    chk("finish_tid", 64'(cmdout_out_tid), 64'(ACC_ID));
                    if (fin_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_finish_word actual=0x%0h required=none", cmdout_out_tdata);
                    end else begin
                        e = fin_q.pop_front();
                        chk("finish_tdata", cmdout_out_tdata, e[63:0]);
                        chk("finish_tlast", 64'(cmdout_out_tlast), 64'(e[64]));
                    end
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    held_d = cmdout_out_tdata;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        finish_now("global_watchdog", 90000);
    end

    initial begin
        int waited;
        rst             = 1'b1;
        cmdin_in_tvalid = 1'b0;
        cmdin_in_tdata  = '0;
        cmdin_in_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        pkt = '{64'h0000_0201, 64'hAA, 64'hBB, 64'h11, 64'h22};
        send_pkt();
        pkt = '{64'h0000_0001, 64'h5, 64'h6};
        send_pkt();
        pkt = '{64'h0000_0007, 64'h1, 64'h2, 64'h3};
        send_pkt();
        pkt = '{64'h0000_0301, 64'hA, 64'hB, 64'h100};
        send_pkt();
        pkt = '{64'h0000_0101, 64'hC, 64'hD, 64'h33};
        send_pkt();
        pkt = '{64'h0000_1001, 64'h1, 64'h2, 64'h3};
        send_pkt();
        pkt = '{64'h0000_0001, 64'hE, 64'hF, 64'h44, 64'h55};
        send_pkt();

        for (int i = 0; i < 40; i++) begin
            gen_random_pkt();
            send_pkt();
        end

        // Reset while the core is running: the task disappears without a finish.
        pkt = '{64'h0000_0101, 64'h61, 64'h62, 64'h63};
        send_pkt();
        hold_done = 1'b1;
        repeat (10) @(negedge clk);
        chk("busy_before_reset", 64'(core_busy), 64'd1);
        rst     = 1'b1;
        abandon = 1'b1;
        err_exp = 0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        check_reset_outputs("reset_next_cycle");
        @(negedge clk);
        rst       = 1'b0;
        hold_done = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_finish_after_reset", 64'(cmdout_out_tvalid), 64'd0);

        pkt = '{64'h0000_0201, 64'h77, 64'h88, 64'h99, 64'hAB};
        send_pkt();

        waited = 0;
        while (start_q.size() != 0 || fin_q.size() != 0 || core_busy) begin
            @(negedge clk);
            waited++;
            if (waited > 3000) finish_now("final_drain_timeout", waited);
        end
        repeat (5) @(negedge clk);
        chk("idle_cmdin_tready", 64'(cmdin_in_tready), 64'd1);
        chk("idle_cmdout_tvalid", 64'(cmdout_out_tvalid), 64'd0);
        chk("pending_finish_words", 64'(fin_q.size()), 64'd0);
`ifdef ACC_CMD_ENDPOINT_ERRCNT_EN
        chk("final_err_count", 64'(err_count), 64'(err_exp));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
